prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 7: consecutive matching bits needed to declare lock.
REQ-002 Parameter UNLOCK_COUNT, default 3: consecutive mismatching bits in LOCKED that force loss of lock.
REQ-003 Parameter CNT_W, default 8: width of err_count.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port data_in, input, 1: received serial PRBS bit.
REQ-007 Port valid_in, input, 1: data_in is sampled only on edges where valid_in=1 (an "accepted bit").
REQ-008 Port locked, output, 1: checker is synchronised to the stream.
REQ-009 Port err, output, 1: one-cycle pulse, accepted bit mismatched while LOCKED.
REQ-010 Port err_count, output, CNT_W: saturating count of err pulses.

Function
REQ-011 The checked sequence SHALL obey b[n] = b[n-1] XOR b[n-3] (3-bit LFSR, period 7; one period is 1,1,1,0,1,0,0).
REQ-012 The block SHALL hold a 3-bit history h (h0 newest, h2 oldest); expected bit = h0 XOR h2.
REQ-013 The state machine SHALL have states FILL, HUNT, LOCKED; reset enters FILL.
REQ-014 FILL: each accepted bit shifts into h; after the 3rd accepted bit the next state SHALL be HUNT.
REQ-015 HUNT: each accepted bit SHALL be compared with expected, then shifted into h (self-synchronising); a match SHALL increment the match counter, and a mismatch SHALL clear it.
REQ-016 HUNT zero guard: if h = 000, the accepted bit SHALL NOT count as a match and SHALL clear the match counter.
REQ-017 When the match counter reaches LOCK_COUNT, the same edge SHALL enter LOCKED and set locked=1.
REQ-018 LOCKED: expected (not data_in) SHALL be shifted into h (flywheel), so a single bit error does not corrupt prediction.
REQ-019 LOCKED mismatch SHALL set err=1 for exactly the following cycle, increment the mismatch counter, and increment err_count.
REQ-020 A LOCKED match SHALL clear the mismatch counter.
REQ-021 When the mismatch counter reaches UNLOCK_COUNT, the same edge SHALL enter HUNT, clear locked and both counters, and load h from data_in.
REQ-022 On an edge with valid_in=0, state, h and counters SHALL hold, and err SHALL be 0.
REQ-023 err_count SHALL saturate at 2^CNT_W-1 and never wrap; it is cleared only by reset.
REQ-024 All outputs SHALL be registered, with latency one edge from the sampled bit; err is never asserted outside LOCKED.

Reset
REQ-025 reset=1 at an edge SHALL force FILL, h=000, counters=0, locked=0, err=0 and err_count=0, regardless of valid_in and current state (including mid-LOCKED).
REQ-026 The first bit accepted after reset deasserts SHALL be the first FILL bit.

Configuration
REQ-027 Macro PRBS_CHECKER_ERR_CNT_EN: when defined, err_count SHALL behave per REQ-019/023; when undefined, the err_count port SHALL remain, be driven constant 0, and no counter SHALL be built; err and locked behaviour are unchanged.

Verification
REQ-028 Reset, then stream 1110100 repeated with valid_in=1 every cycle -> locked=1 after the 10th accepted bit; err never asserts; err_count=0.
REQ-029 After lock, flip one bit (send 0 in place of a 1) -> err high for exactly 1 cycle; err_count=1; locked stays 1; the following bits produce no further errors.
REQ-030 After lock, send 3 consecutive inverted bits -> 3 err pulses, locked=0 after the 3rd; resume the correct stream -> relock after 7 matches.
REQ-031 Drive data_in=0 constantly for 20 cycles after reset -> locked stays 0, err stays 0 (zero guard).
REQ-032 Interleave valid_in=0 cycles holding garbage data_in within the locked stream -> no err and no state change; assert reset mid-LOCKED -> next cycle locked=0, err_count=0.
REQ-033 With CNT_W=2 and the macro defined, inject 5 isolated errors -> err_count saturates at 3; with the macro undefined, err_count stays 0.

Source files
------------

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 3-bit LFSR stream b[n] = b[n-1] ^ b[n-3].
// Optional error counter is built only when PRBS_CHECKER_ERR_CNT_EN is defined.
module prbs_checker #(
  parameter int LOCK_COUNT   = 7,
  parameter int UNLOCK_COUNT = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             valid_in,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);
  localparam int UW = (UNLOCK_COUNT < 2) ? 1 : $clog2(UNLOCK_COUNT);
  localparam logic [MW-1:0] LockLast   = MW'(LOCK_COUNT - 1);
  localparam logic [UW-1:0] UnlockLast = UW'(UNLOCK_COUNT - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    hist_q, hist_d;
  logic [1:0]    fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [UW-1:0] miss_q, miss_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          expBit;
  logic          hit;

  // hist_q[0] is the newest bit, hist_q[2] the oldest.
  assign expBit = hist_q[0] ^ hist_q[2];
  assign hit    = (data_in == expBit);

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    if (valid_in) begin
      case (state_q)
        FILL: begin
          hist_d = {hist_q[1:0], data_in};
          if (fill_q == 2'd2) begin
            state_d = HUNT;
            fill_d  = 2'd0;
          end else begin
            fill_d = fill_q + 2'd1;
          end
        end
        HUNT: begin
          hist_d = {hist_q[1:0], data_in};
          // An all-zero history predicts zeros forever, so it must never build lock.
          if (hit && (hist_q != 3'b000)) begin
            if (match_q == LockLast) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
              miss_d   = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction, not the received bit, feeds the history.
          hist_d = {hist_q[1:0], expBit};
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (miss_q == UnlockLast) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              match_d  = '0;
              miss_d   = '0;
              hist_d   = {hist_q[1:0], data_in};
            end else begin
              miss_d = miss_q + UW'(1);
            end
          end
        end
        default: begin
          state_d  = FILL;
          hist_d   = 3'b000;
          fill_d   = 2'd0;
          match_d  = '0;
          miss_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      hist_q   <= 3'b000;
      fill_q   <= 2'd0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign locked = locked_q;
  assign err    = err_q;

`ifdef PRBS_CHECKER_ERR_CNT_EN
  logic [CNT_W-1:0] errCnt_q, errCnt_d;

  // Saturates at all-ones; only reset brings it back to zero.
  always_comb begin
    errCnt_d = errCnt_q;
    if (err_d && (errCnt_q != {CNT_W{1'b1}})) begin
      errCnt_d = errCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      errCnt_q <= '0;
    end else begin
      errCnt_q <= errCnt_d;
    end
  end

  assign err_count = errCnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, flywheel, unlock, gaps, zero guard, saturation.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_prbs_checker;

`ifdef PRBS_CHECKER_ERR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       dataIn;
  logic       validIn;
  logic       locked, err;
  logic [7:0] errCount;
  logic       locked2, err2;
  logic [1:0] errCount2;

  int checks = 0;
  int errors = 0;

  logic [0:6] pat = 7'b1110100;
  int         phase = 0;
  logic [7:0] cnt8 = 8'd0;
  logic [1:0] cnt2 = 2'd0;

  prbs_checker u_dut (
    .clk(clk), .reset(reset), .data_in(dataIn), .valid_in(validIn),
    .locked(locked), .err(err), .err_count(errCount)
  );

  prbs_checker #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .data_in(dataIn), .valid_in(validIn),
    .locked(locked2), .err(err2), .err_count(errCount2)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs, then settle just after the edge.
  task automatic applyStimulus(input logic d, input logic v);
    dataIn  = d;
    validIn = v;
    @(posedge clk);
    #1;
  endtask

  task automatic sendGood();
    applyStimulus(pat[phase], 1'b1);
    phase = (phase == 6) ? 0 : phase + 1;
  endtask

  // Inverted bit; only called while the checker is locked, so the models count it.
  task automatic sendBad();
    applyStimulus(~pat[phase], 1'b1);
    phase = (phase == 6) ? 0 : phase + 1;
    cnt8 = (cnt8 == 8'hFF) ? cnt8 : cnt8 + 8'd1;
    cnt2 = (cnt2 == 2'd3) ? cnt2 : cnt2 + 2'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked got %b expected 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b expected 0", err); end
    checks++; if (errCount !== 8'd0) begin errors++; $display("[TB] FAIL reset_errcount got %0d expected 0", errCount); end
  endtask

  task automatic test_lock();
    reset = 1'b0;
    phase = 0;
    for (int k = 1; k <= 20; k++) begin
      sendGood();
      checks++; if (locked !== (k >= 10)) begin errors++; $display("[TB] FAIL lock_locked bit %0d got %b expected %b", k, locked, (k >= 10)); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL lock_err bit %0d got %b expected 0", k, err); end
    end
    checks++; if (locked2 !== 1'b1) begin errors++; $display("[TB] FAIL lock_locked2 got %b expected 1", locked2); end
    checks++; if (errCount !== 8'd0) begin errors++; $display("[TB] FAIL lock_errcount got %0d expected 0", errCount); end
  endtask

  task automatic test_single_error();
    for (int g = 0; g < 7 && pat[phase] != 1'b1; g++) sendGood();
    sendBad();
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL single_err got %b expected 1", err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL single_locked got %b expected 1", locked); end
    checks++; if (errCount !== (CntEn ? cnt8 : 8'd0)) begin errors++; $display("[TB] FAIL single_errcount got %0d expected %0d", errCount, (CntEn ? cnt8 : 8'd0)); end
    for (int k = 1; k <= 14; k++) begin
      sendGood();
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL single_after_err bit %0d got %b expected 0", k, err); end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL single_after_locked bit %0d got %b expected 1", k, locked); end
    end
  endtask

  task automatic test_unlock();
    for (int k = 1; k <= 3; k++) begin
      sendBad();
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL unlock_err bad %0d got %b expected 1", k, err); end
      checks++; if (locked !== (k < 3)) begin errors++; $display("[TB] FAIL unlock_locked bad %0d got %b expected %b", k, locked, (k < 3)); end
    end
    checks++; if (errCount !== (CntEn ? cnt8 : 8'd0)) begin errors++; $display("[TB] FAIL unlock_errcount got %0d expected %0d", errCount, (CntEn ? cnt8 : 8'd0)); end
    // The inverted bit taken into history spoils two predictions, so 7 clean matches finish on good bit 10.
    for (int k = 1; k <= 12; k++) begin
      sendGood();
      checks++; if (locked !== (k >= 10)) begin errors++; $display("[TB] FAIL relock_locked bit %0d got %b expected %b", k, locked, (k >= 10)); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL relock_err bit %0d got %b expected 0", k, err); end
    end
  endtask

  task automatic test_valid_gaps();
    for (int k = 1; k <= 14; k++) begin
      sendGood();
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL gap_good_err bit %0d got %b expected 0", k, err); end
      applyStimulus(1'($urandom_range(1, 0)), 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL gap_idle_err bit %0d got %b expected 0", k, err); end
      checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL gap_idle_locked bit %0d got %b expected 1", k, locked); end
    end
    checks++; if (errCount !== (CntEn ? cnt8 : 8'd0)) begin errors++; $display("[TB] FAIL gap_errcount got %0d expected %0d", errCount, (CntEn ? cnt8 : 8'd0)); end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1);
    cnt8 = 8'd0;
    cnt2 = 2'd0;
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL midreset_locked got %b expected 0", locked); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err got %b expected 0", err); end
    checks++; if (errCount !== 8'd0) begin errors++; $display("[TB] FAIL midreset_errcount got %0d expected 0", errCount); end
    checks++; if (errCount2 !== 2'd0) begin errors++; $display("[TB] FAIL midreset_errcount2 got %0d expected 0", errCount2); end
  endtask

  task automatic test_zero_guard();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, 1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL zero_locked bit %0d got %b expected 0", k, locked); end
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL zero_err bit %0d got %b expected 0", k, err); end
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
    cnt8 = 8'd0;
    cnt2 = 2'd0;
    phase = 0;
    for (int k = 1; k <= 10; k++) sendGood();
    checks++; if (locked2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_locked2 got %b expected 1", locked2); end
    for (int e = 1; e <= 5; e++) begin
      sendBad();
      checks++; if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_err2 error %0d got %b expected 1", e, err2); end
      checks++; if (errCount2 !== (CntEn ? cnt2 : 2'd0)) begin errors++; $display("[TB] FAIL sat_errcount2 error %0d got %0d expected %0d", e, errCount2, (CntEn ? cnt2 : 2'd0)); end
      for (int g = 0; g < 3; g++) sendGood();
      checks++; if (locked2 !== 1'b1) begin errors++; $display("[TB] FAIL sat_locked2 error %0d got %b expected 1", e, locked2); end
    end
    checks++; if (errCount2 !== (CntEn ? 2'd3 : 2'd0)) begin errors++; $display("[TB] FAIL sat_final2 got %0d expected %0d", errCount2, (CntEn ? 2'd3 : 2'd0)); end
    checks++; if (errCount !== (CntEn ? 8'd5 : 8'd0)) begin errors++; $display("[TB] FAIL sat_final8 got %0d expected %0d", errCount, (CntEn ? 8'd5 : 8'd0)); end
  endtask

  initial begin
    reset   = 1'b1;
    dataIn  = 1'b0;
    validIn = 1'b0;
    $display("[TB] prbs_checker bench, err counter enabled = %0d", CntEn);
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_valid_gaps();
    test_zero_guard();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
